// File: rtl/dsp_result_capture_if.sv
// Capture-port bundle for dsp_result_capture: strobe/z sampling inputs, run control and result outputs.
// master drives the run (bench/controller side); slave is the capture block itself.
interface dsp_result_capture_if #(
  parameter int ZW = 108
);
  logic          strobe;
  logic [ZW-1:0] z;
  logic          start;
  logic [15:0]   n_samples;
  logic          busy;
  logic          done;
  logic [31:0]   signature;
  logic [15:0]   count;
  logic [ZW-1:0] last_z;
  logic [1:0]    dbg_state;

  modport master (
    output strobe, z, start, n_samples,
    input  busy, done, signature, count, last_z, dbg_state
  );

  modport slave (
    input  strobe, z, start, n_samples,
    output busy, done, signature, count, last_z, dbg_state
  );
endinterface

// File: rtl/dsp_result_capture.sv
// Folds LATENCY-delayed, strobe-qualified DSP results into a 32-bit MISR over a run of n_samples.
// Optional last_z register is built only when DSP_CAPTURE_LAST_Z_EN is defined.
module dsp_result_capture #(
  parameter int LATENCY = 1,
  parameter int ZW      = 108
) (
  input logic                 clk,
  input logic                 rst,
  dsp_result_capture_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       r_state;
  logic         r_busy;
  logic         r_done;
  logic [31:0]  r_sig;
  logic [15:0]  r_count;
  logic [15:0]  r_limit;
  logic         w_stb_d;
  logic         w_fold_en;
  logic [127:0] w_z_ext;
  logic [31:0]  w_fold;
  logic [31:0]  w_sig_next;

  // Strobe delay line runs every cycle, independent of the FSM.
  generate
    if (LATENCY == 0) begin : g_no_delay
      assign w_stb_d = bus.strobe;
    end else begin : g_delay
      logic [LATENCY-1:0] r_stb_pipe;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_stb_pipe <= '0;
        end else begin
          r_stb_pipe[0] <= bus.strobe;
          for (int i = 1; i < LATENCY; i++) begin
            r_stb_pipe[i] <= r_stb_pipe[i-1];
          end
        end
      end
      assign w_stb_d = r_stb_pipe[LATENCY-1];
    end
  endgenerate

  always_comb begin
    w_z_ext         = '0;
    w_z_ext[ZW-1:0] = bus.z;
    w_fold          = w_z_ext[31:0] ^ w_z_ext[63:32] ^ w_z_ext[95:64] ^ w_z_ext[127:96];
    w_sig_next      = ({r_sig[30:0], 1'b0} ^ (r_sig[31] ? 32'h04C11DB7 : 32'h0)) ^ w_fold;
  end

  // start wins over a coincident delayed strobe.
  assign w_fold_en = (r_state == S_RUN) && w_stb_d && !bus.start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sig   <= '0;
      r_count <= '0;
      r_limit <= '0;
    end else if (bus.start) begin
      r_sig   <= '0;
      r_count <= '0;
      r_limit <= bus.n_samples;
      if (bus.n_samples == 16'd0) begin
        r_state <= S_DONE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end else begin
        r_state <= S_RUN;
        r_busy  <= 1'b1;
        r_done  <= 1'b0;
      end
    end else if (w_fold_en) begin
      r_sig   <= w_sig_next;
      r_count <= r_count + 16'd1;
      if (r_count + 16'd1 == r_limit) begin
        r_state <= S_DONE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end
    end
  end

`ifdef DSP_CAPTURE_LAST_Z_EN
  logic [ZW-1:0] r_last_z;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_z <= '0;
    end else if (bus.start) begin
      r_last_z <= '0;
    end else if (w_fold_en) begin
      r_last_z <= bus.z;
    end
  end
  assign bus.last_z = r_last_z;
`else
  assign bus.last_z = '0;
`endif

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.signature = r_sig;
  assign bus.count     = r_count;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_dsp_result_capture.sv
// Directed bench for dsp_result_capture: LATENCY=1 and LATENCY=2 instances, hand-computed MISR values.
module tb_dsp_result_capture;
  localparam int ZW = 108;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [ZW-1:0] exp_last_z;

  dsp_result_capture_if #(.ZW(ZW)) if1 ();
  dsp_result_capture_if #(.ZW(ZW)) if2 ();

  dsp_result_capture #(.LATENCY(1), .ZW(ZW)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  dsp_result_capture #(.LATENCY(2), .ZW(ZW)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic start1(input logic [15:0] n);
    if1.n_samples = n;
    if1.start     = 1'b1;
    tick();
    if1.start     = 1'b0;
  endtask

  task automatic start2(input logic [15:0] n);
    if2.n_samples = n;
    if2.start     = 1'b1;
    tick();
    if2.start     = 1'b0;
  endtask

  // LATENCY=1: strobe this cycle, z presented the next cycle.
  task automatic sample1(input logic [ZW-1:0] zv);
    if1.strobe = 1'b1;
    tick();
    if1.strobe = 1'b0;
    if1.z      = zv;
    tick();
    if1.z      = '0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    if1.strobe = 1'b0; if1.z = '0; if1.start = 1'b0; if1.n_samples = '0;
    if2.strobe = 1'b0; if2.z = '0; if2.start = 1'b0; if2.n_samples = '0;
    tick();
    tick();
    check("rst_busy",  if1.busy, 1'b0);
    check("rst_done",  if1.done, 1'b0);
    check("rst_sig",   if1.signature, 32'h0);
    check("rst_count", if1.count, 16'd0);
    check("rst_lastz", if1.last_z, '0);
    check("rst_state", if1.dbg_state, 2'd0);
    check("rst_sig2",  if2.signature, 32'h0);
    rst = 1'b0;
    tick();

    // zero-length run
    start1(16'd0);
    check("n0_done",  if1.done, 1'b1);
    check("n0_busy",  if1.busy, 1'b0);
    check("n0_sig",   if1.signature, 32'h0);
    check("n0_count", if1.count, 16'd0);
    tick();
    check("n0_busy_hold", if1.busy, 1'b0);
    check("n0_done_hold", if1.done, 1'b1);

    // two samples of z=1
    start1(16'd2);
    check("r2_busy",  if1.busy, 1'b1);
    check("r2_state", if1.dbg_state, 2'd1);
    sample1(1);
    check("r2_sig1",   if1.signature, 32'h1);
    check("r2_count1", if1.count, 16'd1);
    sample1(1);
    check("r2_sig2",   if1.signature, 32'h3);
    check("r2_count2", if1.count, 16'd2);
    check("r2_done",   if1.done, 1'b1);
    check("r2_busy0",  if1.busy, 1'b0);

    // strobes after DONE are ignored
    sample1(9);
    check("done_cnt_hold", if1.count, 16'd2);
    check("done_sig_hold", if1.signature, 32'h3);

    // z=(1<<96)|1 folds to zero
    start1(16'd1);
    exp_last_z = '0;
    exp_last_z[96] = 1'b1;
    exp_last_z[0]  = 1'b1;
    sample1(exp_last_z);
    check("fold0_sig",   if1.signature, 32'h0);
    check("fold0_count", if1.count, 16'd1);
    check("fold0_done",  if1.done, 1'b1);
`ifdef DSP_CAPTURE_LAST_Z_EN
    check("fold0_lastz", if1.last_z, exp_last_z);
`else
    check("fold0_lastz", if1.last_z, '0);
`endif

    // start coincident with a delayed strobe: start wins, sample dropped
    start1(16'd2);
    if1.strobe = 1'b1;
    tick();
    if1.strobe    = 1'b0;
    if1.z         = 3;
    if1.start     = 1'b1;
    if1.n_samples = 16'd2;
    tick();
    if1.start = 1'b0;
    if1.z     = '0;
    check("prio_sig",   if1.signature, 32'h0);
    check("prio_count", if1.count, 16'd0);
    check("prio_busy",  if1.busy, 1'b1);
    check("prio_lastz", if1.last_z, '0);
    sample1(6);
    check("prio_sig6", if1.signature, 32'h6);
    sample1(0);
    check("shift_sig", if1.signature, 32'hC);
    check("shift_done", if1.done, 1'b1);

    // MISR feedback when bit31 is set; high chunk folding
    start1(16'd3);
    sample1(32'h8000_0000);
    check("fb_sig1", if1.signature, 32'h8000_0000);
    sample1(0);
    check("fb_sig2", if1.signature, 32'h04C1_1DB7);
    exp_last_z = '0;
    exp_last_z[71:64] = 8'hF0;
    exp_last_z[3:0]   = 4'hF;
    sample1(exp_last_z);
    // (0x04C11DB7<<1) ^ 0xFF = 0x09823B6E ^ 0xFF = 0x09823B91
    check("fb_sig3", if1.signature, 32'h0982_3B91);
    check("fb_count", if1.count, 16'd3);

    // LATENCY=2: z must line up with t+2
    start2(16'd1);
    if2.strobe = 1'b1;
    tick();
    if2.strobe = 1'b0;
    tick();
    if2.z = 5;
    tick();
    if2.z = '0;
    check("lat2_sig",   if2.signature, 32'h5);
    check("lat2_count", if2.count, 16'd1);
    check("lat2_done",  if2.done, 1'b1);
    start2(16'd1);
    if2.strobe = 1'b1;
    tick();
    if2.strobe = 1'b0;
    if2.z = 5;
    tick();
    if2.z = '0;
    tick();
    check("lat2_early_sig",   if2.signature, 32'h0);
    check("lat2_early_count", if2.count, 16'd1);

    // reset mid-run abandons the run
    start1(16'd3);
    sample1(7);
    check("mid_sig", if1.signature, 32'h7);
    if1.strobe = 1'b1;
    tick();
    if1.strobe = 1'b0;
    if1.z      = 8;
    #2;
    rst = 1'b1;
    #1;
    check("arst_sig",   if1.signature, 32'h0);
    check("arst_count", if1.count, 16'd0);
    check("arst_busy",  if1.busy, 1'b0);
    check("arst_state", if1.dbg_state, 2'd0);
    check("arst_lastz", if1.last_z, '0);
    tick();
    rst = 1'b0;
    if1.z = '0;
    sample1(4);
    check("post_sig",   if1.signature, 32'h0);
    check("post_count", if1.count, 16'd0);
    check("post_busy",  if1.busy, 1'b0);
    check("post_done",  if1.done, 1'b0);
    check("post_state", if1.dbg_state, 2'd0);

    // new run after reset works
    start1(16'd1);
    sample1(2);
    check("new_sig",  if1.signature, 32'h2);
    check("new_done", if1.done, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dsp_result_capture.md
DSP_RESULT_CAPTURE -- requirements
Module: dsp_result_capture

Interface
REQ-001 Parameter LATENCY, default 1, cycles from strobe to valid z (legal 0..4).
REQ-002 Parameter ZW, default 108, width of DSP result bus.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 strobe  input  1  same strobe that qualifies the DSP under test's CE/RST controls.
REQ-006 z  input  ZW  DSP result bus (Z output of the multiply-add stage).
REQ-007 start  input  1  one-cycle pulse; clears state and begins a capture run.
REQ-008 n_samples  input  16  number of samples per run; sampled on start.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  high while in DONE.
REQ-011 signature  output  32  running MISR value.
REQ-012 count  output  16  samples folded in the current run.
REQ-013 last_z  output  ZW  most recent sampled z (see Configuration).

Function
REQ-014 A LATENCY-stage shift register of strobe SHALL shift every cycle regardless of state; tap stb_d is strobe itself when LATENCY=0, else the last stage.
REQ-015 States: IDLE, RUN, DONE; encoding free.
REQ-016 IDLE/RUN/DONE + start: signature<=0, count<=0, limit<=n_samples; next RUN, or DONE if n_samples==0.
REQ-017 start SHALL take priority over sampling in the same cycle; that cycle's stb_d is discarded.
REQ-018 RUN, stb_d=1, no start: fold z; count<=count+1; if count+1==limit go DONE same edge.
REQ-019 fold(z): z zero-extended to 128 bits, XOR of the four 32-bit chunks.
REQ-020 MISR update: sig<=({sig[30:0],1'b0} ^ (sig[31] ? 32'h04C11DB7 : 0)) ^ fold(z).
REQ-021 In IDLE and DONE, stb_d SHALL be ignored; signature and count hold.
REQ-022 count SHALL never exceed limit; no wrap-around within a run.
REQ-023 busy, done, signature, count SHALL be registered outputs, no combinational path from inputs.

Reset
REQ-024 rst asserted: state IDLE, strobe pipeline all 0, signature 0, count 0, limit 0, last_z 0, busy 0, done 0.
REQ-025 rst asserted mid-RUN SHALL abandon the run immediately; no partial sample completes.
REQ-026 First sample after rst release requires a strobe issued after release.

Configuration
REQ-027 Macro DSP_CAPTURE_LAST_Z_EN.
REQ-028 Defined: last_z loads z on every edge where a fold occurs (REQ-018), cleared by start.
REQ-029 Undefined: no last_z register is built; last_z SHALL be driven constant 0.

Verification
REQ-030 n_samples=0, start -> done=1 next cycle, signature=0x00000000, count=0, busy never high.
REQ-031 LATENCY=1, n_samples=2, start, strobe with z=1 presented next cycle, repeat -> signature 0x00000001 then 0x00000003, count 2, done=1.
REQ-032 z=(1<<96)|1 single sample -> fold 0, signature stays 0x00000000, count=1.
REQ-033 LATENCY=2, strobe at cycle t, z=5 only at t+2 (else 0) -> signature 0x00000005; z=5 moved to t+1 -> signature 0.
REQ-034 rst pulse after first of 3 samples -> all outputs 0, state IDLE; following strobes ignored until new start.
REQ-035 With DSP_CAPTURE_LAST_Z_EN, last_z equals final folded z; without it last_z=0 throughout.
